// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues in-order imem reads under queue credit
// and pairs each response with its PC for the downstream instruction queue.

// Small generic FIFO; push and pop in the same cycle are allowed.
// Zero read latency: pop_dat shows the head entry combinationally.
// No internal backpressure: the caller must never push when full or pop when empty.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_vld) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CW'(push_vld) - CW'(pop_vld);
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_vld && full && !pop_vld));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_vld && empty));
endmodule

// Fetch stage: PC sequencer, outstanding-request tracking and redirect drain.
// Zero latency: a response is enqueued downstream in the cycle it arrives.
// Backpressure: requests stall on imem_ready, on MAX_OUTSTANDING, or when outstanding >= q_freespace.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1eceb000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          QDEPTH_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  output logic [3:0]           imem_rmask,
  input  logic                 imem_ready,
  input  logic                 imem_resp,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic [QDEPTH_BITS:0] q_freespace,
  output logic                 q_enqueue,
  output logic [63:0]          q_din
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [OW-1:0] discard_after_redirect;

  logic          accept;
  logic          resp_ok;
  logic          has_credit;
  logic [31:0]   head_pc;
  logic          fifo_full;
  logic          fifo_empty;

  // A response with nothing outstanding is illegal and is ignored entirely.
  assign resp_ok    = imem_resp && (outstanding != '0);
  assign has_credit = (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                      (32'(outstanding) < 32'(q_freespace));

  assign imem_req   = !rst && (state == RUN) && !redirect_valid && has_credit;
  assign imem_addr  = pc;
  assign imem_rmask = imem_req ? 4'b1111 : 4'b0000;
  assign accept     = imem_req && imem_ready;

  assign q_enqueue  = !rst && (state == RUN) && !redirect_valid && resp_ok;
  assign q_din      = {head_pc, imem_rdata};

  assign discard_after_redirect = outstanding - OW'(resp_ok);

  fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (accept),
    .push_dat (pc),
    .pop_vld  (resp_ok && !rst),
    .pop_dat  (head_pc),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(resp_ok);
      if (redirect_valid) begin
        // Every request still in flight after this cycle returns stale data.
        pc      <= redirect_pc;
        discard <= discard_after_redirect;
        state   <= (discard_after_redirect != '0) ? DRAIN : RUN;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if ((state == DRAIN) && resp_ok) begin
          discard <= discard - OW'(1);
          if (discard == OW'(1)) begin
            state <= RUN;
          end
        end
      end
    end
  end

  a_resp_legal:   assert property (@(posedge clk) disable iff (rst) imem_resp |-> (outstanding != '0));
  a_enq_has_resp: assert property (@(posedge clk) disable iff (rst) q_enqueue |-> imem_resp);
  a_fifo_empty:   assert property (@(posedge clk) disable iff (rst) (outstanding == '0) == fifo_empty);
  a_fifo_full:    assert property (@(posedge clk) disable iff (rst)
                                   (32'(outstanding) == 32'(MAX_OUTSTANDING)) == fifo_full);
  a_addr_stable:  assert property (@(posedge clk) disable iff (rst)
                                   (imem_req && !imem_ready && !redirect_valid) |=> (imem_addr == $past(imem_addr)));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          MAXO     = 2;
  localparam int          QB       = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [3:0]    imem_rmask;
  logic          imem_ready;
  logic          imem_resp;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [QB:0]   q_freespace;
  logic          q_enqueue;
  logic [63:0]   q_din;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC        (RESET_PC),
    .MAX_OUTSTANDING (MAXO),
    .QDEPTH_BITS     (QB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_ready     (imem_ready),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_freespace    (q_freespace),
    .q_enqueue      (q_enqueue),
    .q_din          (q_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [QB:0] fs;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_enq;
    logic [31:0] e_hi;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } pend_t;

  vec_t  vecs[$];
  pend_t pend[$];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy, logic rsp,
                              logic [QB:0] fs, logic er, logic [31:0] ea, logic ee, logic [31:0] eh);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.fs = fs;
    v.e_req = er; v.e_addr = ea; v.e_enq = ee; v.e_hi = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic rsp, input logic [31:0] rd, input logic [QB:0] fs);
    rst = r; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy;
    imem_resp = rsp; imem_rdata = rd; q_freespace = fs;
    #3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int late_req;
    int req_seen;
    logic [31:0] m_pc;
    logic [31:0] rd;
    logic r, rv, rdy, rsp, e_req, e_enq, stale_any;
    logic [31:0] rpc;
    logic [QB:0] fs;

    // Directed sequence: streaming fetch, redirect with drain, redirect on response, stall, credit.
    vecs.push_back(mk(1, 0, 0,            1, 0, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 1, 32'h1eceb000, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 1, 16, 1, 32'h1eceb004, 1, 32'h1eceb000));
    vecs.push_back(mk(0, 0, 0,            1, 1, 16, 1, 32'h1eceb008, 1, 32'h1eceb004));
    vecs.push_back(mk(0, 0, 0,            0, 1, 16, 1, 32'h1eceb00c, 1, 32'h1eceb008));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 1, 32'h1eceb00c, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 1, 32'h1eceb010, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 1, 32'h00001000, 1, 0, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 1, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 1, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 1, 32'h00001000, 0, 0));
    vecs.push_back(mk(0, 1, 32'h00002000, 1, 1, 16, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 16, 1, 32'h00002000, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 16, 1, 32'h00002000, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 16, 1, 32'h00002000, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 16, 1, 32'h00002000, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 1,  0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 1, 1,  0, 0,            1, 32'h00002000));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0,  0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 1,  1, 32'h00002004, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rd = 32'hc0de0000 + 32'(i);
      drive(vecs[i].r, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rsp, rd, vecs[i].fs);
      chk($sformatf("vec%0d req", i), 64'(imem_req), 64'(vecs[i].e_req));
      chk($sformatf("vec%0d rmask", i), 64'(imem_rmask), vecs[i].e_req ? 64'hf : 64'h0);
      if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d enq", i), 64'(q_enqueue), 64'(vecs[i].e_enq));
      if (vecs[i].e_enq) chk($sformatf("vec%0d din", i), q_din, {vecs[i].e_hi, rd});
      step();
    end

    // Single queue slot, memory silent for 5 cycles: exactly one request.
    drive(1, 0, 0, 1, 0, 0, 16);
    step();
    acc = 0; late_req = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 0, 1);
      if (acc > 0 && imem_req) late_req++;
      if (imem_req && imem_ready) acc++;
      step();
    end
    chk("fs1 accepts", 64'(acc), 64'd1);
    chk("fs1 req held low", 64'(late_req), 64'd0);
    drive(0, 0, 0, 1, 1, 32'h12345678, 1);
    chk("fs1 resp enq", 64'(q_enqueue), 64'd1);
    chk("fs1 resp din", q_din, {RESET_PC, 32'h12345678});
    step();
    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      if (imem_req) req_seen++;
      step();
    end
    chk("fs0 no req", 64'(req_seen), 64'd0);

    // Reset with two requests outstanding abandons them.
    drive(1, 0, 0, 1, 0, 0, 16);
    step();
    drive(0, 0, 0, 1, 0, 0, 16);
    chk("rst2 addr0", 64'(imem_addr), 64'(RESET_PC));
    step();
    drive(0, 0, 0, 1, 0, 0, 16);
    chk("rst2 addr1", 64'(imem_addr), 64'(RESET_PC + 32'd4));
    step();
    drive(1, 0, 0, 1, 0, 0, 16);
    chk("rst2 req in rst", 64'(imem_req), 64'd0);
    chk("rst2 enq in rst", 64'(q_enqueue), 64'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rst2 req after", 64'(imem_req), 64'd1);
    chk("rst2 addr after", 64'(imem_addr), 64'(RESET_PC));
    step();

    // Randomized traffic vs. model: pending requests tagged stale on redirect.
    m_pc = RESET_PC;
    pend.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r   = (cyc == 0) || ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom() & 32'hffff_fffc;
      rdy = ($urandom_range(0, 9) < 7);
      rsp = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      fs  = ($urandom_range(0, 3) == 0) ? QB'($urandom_range(0, 2)) : 5'($urandom_range(0, 16));
      rd  = $urandom();
      stale_any = 1'b0;
      foreach (pend[k]) if (pend[k].stale) stale_any = 1'b1;
      e_req = !r && !rv && !stale_any && (pend.size() < MAXO) && (pend.size() < int'(fs));
      e_enq = !r && !rv && rsp && !pend[0].stale;
      drive(r, rv, rpc, rdy, rsp, rd, fs);
      chk("rnd req", 64'(imem_req), 64'(e_req));
      chk("rnd rmask", 64'(imem_rmask), e_req ? 64'hf : 64'h0);
      if (e_req) chk("rnd addr", 64'(imem_addr), 64'(m_pc));
      chk("rnd enq", 64'(q_enqueue), 64'(e_enq));
      if (e_enq) chk("rnd din", q_din, {pend[0].pc, rd});
      if (r) begin
        pend.delete();
        m_pc = RESET_PC;
      end else begin
        if (rsp) void'(pend.pop_front());
        if (rv) begin
          foreach (pend[k]) pend[k].stale = 1'b1;
          m_pc = rpc;
        end else if (e_req && rdy) begin
          pend.push_back('{pc: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
